// File: rtl/mux_sel_arbiter_pkg.sv
// Shared definitions for the mux_sel_arbiter slice.
//   N_SRC     : number of requesting sources (inputs of the downstream mux4_1)
//   SEL_W     : width of the mux select
//   state_t   : arbiter FSM states
//   sel_onehot: select value -> one-hot grant vector
package mux_sel_arbiter_pkg;

  localparam int unsigned N_SRC = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  function automatic logic [N_SRC-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [N_SRC-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin winner selection over four requests.
//   req  in  4  request vector
//   last in  2  index of the most recently released source
//   win  out 2  first set request scanning last+1, last+2, ... modulo 4
//   any  out 1  at least one request is set (win is only meaningful then)
module rr_pick4
  import mux_sel_arbiter_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic [SEL_W-1:0] win,
  output logic             any
);

  logic [SEL_W-1:0] idx;
  logic             found;

  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    any   = |req;
    // Offsets 1..N_SRC; the 2-bit sum wraps so the last-served source is scanned last.
    for (int unsigned i = 1; i <= N_SRC; i++) begin
      idx = last + SEL_W'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the 2-bit select of the downstream mux4_1.
// Each grant lasts at least HOLD_CYCLES cycles; it ends when the hold has
// expired and either the consumer signalled done (now or during the hold)
// or the granted source dropped its request.
//   clk    in   1  rising-edge clock
//   rst_n  in   1  asynchronous active-low reset
//   req    in   4  per-source request; bit i selects mux input i
//   done   in   1  single-cycle pulse: current transfer finished
//   s      out  2  registered mux select, stable for the whole grant
//   gnt    out  4  registered one-hot grant, zero when idle
//   busy   out  1  registered, equals |gnt
module mux_sel_arbiter
  import mux_sel_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] req,
  input  logic             done,
  output logic [SEL_W-1:0] s,
  output logic [N_SRC-1:0] gnt,
  output logic             busy
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             done_seen;
  logic [SEL_W-1:0] last;

  logic [SEL_W-1:0] win;
  logic             any;
  logic             hold_over;
  logic             release_ok;

  rr_pick4 u_pick (
    .req  (req),
    .last (last),
    .win  (win),
    .any  (any)
  );

  always_comb begin
    hold_over  = (cnt == '0);
    release_ok = hold_over && (done || done_seen || !req[s]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      s         <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      cnt       <= '0;
      done_seen <= 1'b0;
      last      <= '1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any) begin
            s         <= win;
            gnt       <= sel_onehot(win);
            busy      <= 1'b1;
            cnt       <= HOLD_LOAD;
            done_seen <= 1'b0;
            state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (release_ok) begin
            gnt   <= '0;
            busy  <= 1'b0;
            last  <= s;
            state <= ST_IDLE;
          end else if (!hold_over) begin
            // A done arriving during the hold is remembered, not acted on early.
            cnt <= cnt - CNT_W'(1);
            if (done) begin
              done_seen <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_arbiter.sv
module tb_mux_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [1:0] s;
  logic [3:0] gnt;
  logic       busy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  mux_sel_arbiter #(
    .HOLD_CYCLES (4),
    .CNT_W       (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .done  (done),
    .s     (s),
    .gnt   (gnt),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [1:0] es, input logic [3:0] eg, input logic eb);
    check({tag, ".s"},    {6'd0, s},    {6'd0, es});
    check({tag, ".gnt"},  {4'd0, gnt},  {4'd0, eg});
    check({tag, ".busy"}, {7'd0, busy}, {7'd0, eb});
  endtask

  // Expected select order for the round-robin pass with all four requesting.
  logic [1:0] rr_exp [4] = '{2'd0, 2'd1, 2'd2, 2'd3};

  initial begin
    // T1 reset with all requests raised
    req = 4'b1111;
    #1 rst_n = 1'b0;
    tick(3);
    check_out("t1_reset", 2'b00, 4'b0000, 1'b0);
    rst_n = 1'b1;
    tick(1);
    check_out("t1_first_grant", 2'b00, 4'b0001, 1'b1);
    req = 4'b0000;
    tick(4);
    check_out("t1_release", 2'b00, 4'b0000, 1'b0);

    // T2 minimum hold: one-cycle request from source 1
    req = 4'b0010;
    tick(1);
    check_out("t2_grant", 2'b01, 4'b0010, 1'b1);
    req = 4'b0000;
    for (int unsigned k = 0; k < 3; k++) begin
      tick(1);
      check("t2_hold.gnt", {4'd0, gnt}, 8'h02);
    end
    tick(1);
    check_out("t2_release", 2'b01, 4'b0000, 1'b0);

    // Fresh reset so the round-robin pass starts from last=3
    rst_n = 1'b0;
    #1 check_out("t3_prereset", 2'b00, 4'b0000, 1'b0);
    tick(1);
    rst_n = 1'b1;

    // T3 round robin: all request, done pulsed when the hold expires
    req = 4'b1111;
    for (int unsigned k = 0; k < 4; k++) begin
      tick(1);
      check_out("t3_grant", rr_exp[k], 4'b0001 << rr_exp[k], 1'b1);
      tick(3);
      check("t3_hold_at_zero.gnt", {4'd0, gnt}, {4'd0, 4'b0001 << rr_exp[k]});
      done = 1'b1;
      tick(1);
      done = 1'b0;
      check_out("t3_gap", rr_exp[k], 4'b0000, 1'b0);
    end

    // T5 wrap: last=3, sources 0 and 3 requesting
    req = 4'b1001;
    tick(1);
    check_out("t5_first", 2'b00, 4'b0001, 1'b1);
    tick(3);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    check_out("t5_gap", 2'b00, 4'b0000, 1'b0);
    tick(1);
    check_out("t5_second", 2'b11, 4'b1000, 1'b1);
    req = 4'b0000;
    tick(4);
    check_out("t5_release", 2'b11, 4'b0000, 1'b0);

    // T4 early done is remembered until the hold expires
    req = 4'b0100;
    tick(1);
    check_out("t4_grant", 2'b10, 4'b0100, 1'b1);
    tick(1);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    check("t4_no_early.gnt", {4'd0, gnt}, 8'h04);
    tick(1);
    check("t4_hold_end.gnt", {4'd0, gnt}, 8'h04);
    tick(1);
    check_out("t4_release", 2'b10, 4'b0000, 1'b0);
    tick(1);
    check_out("t4_regrant", 2'b10, 4'b0100, 1'b1);

    // Hand over to source 3 by dropping source 2
    req = 4'b1000;
    tick(4);
    check("t6_pre_release.gnt", {4'd0, gnt}, 8'h00);
    tick(1);
    check_out("t6_grant", 2'b11, 4'b1000, 1'b1);

    // T6 async reset mid-grant with a pending early done
    done = 1'b1;
    tick(1);
    done = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_out("t6_async", 2'b00, 4'b0000, 1'b0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    check_out("t6_regrant", 2'b11, 4'b1000, 1'b1);
    tick(4);
    check("t6_done_seen_lost.gnt", {4'd0, gnt}, 8'h08);
    done = 1'b1;
    tick(1);
    done = 1'b0;
    check_out("t6_release", 2'b11, 4'b0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
